// File: rtl/pkt_gen_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator.
package pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_ABORT = 2'd2,
        ST_GAP   = 2'd3
    } pkt_state_t;

    localparam int PKT_IDX_BITS = 8;

    function automatic int bpb(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI-Stream bus carrying tuser_mty (empty byte count on the last beat).
interface axis_pkt_gen_if #(
    parameter int DATA_WIDTH = 64,
    parameter int MTY_WIDTH  = 3
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [MTY_WIDTH-1:0]  tuser_mty;

    modport master (output tvalid, output tdata, output tlast, output tuser_mty, input tready);
    modport slave  (input tvalid, input tdata, input tlast, input tuser_mty, output tready);
endinterface

// File: rtl/axis_beat_fmt.sv
// Builds one beat of the incrementing byte pattern: lane i carries base + offset + i,
// lanes past the end of the packet are zeroed.
module axis_beat_fmt
    import pkt_gen_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int C_MTY_WIDTH  = 3,
    parameter int C_LEN_BITS   = 16
) (
    input  logic [7:0]              pkt_base,
    input  logic [7:0]              byte_off,
    input  logic [C_LEN_BITS-1:0]   bytes_left,
    output logic [C_DATA_WIDTH-1:0] tdata,
    output logic                    tlast,
    output logic [C_MTY_WIDTH-1:0]  mty
);
    localparam int BPB = bpb(C_DATA_WIDTH);

    logic [7:0] beat_base;
    assign beat_base = pkt_base + byte_off;

    generate
        for (genvar gi = 0; gi < BPB; gi++) begin : g_lane
            assign tdata[gi*8 +: 8] = (bytes_left > C_LEN_BITS'(gi)) ? (beat_base + 8'(gi)) : 8'h00;
        end
    endgenerate

    assign tlast = (bytes_left <= C_LEN_BITS'(BPB));
    assign mty   = tlast ? C_MTY_WIDTH'(C_LEN_BITS'(BPB) - bytes_left) : '0;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: configurable length/count/pattern, backpressure-aware,
// abandons a packet stalled mid-flight and signals the drop to the downstream queue.
module axis_pkt_gen
    import pkt_gen_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 64,
    parameter int C_MTY_WIDTH   = 3,
    parameter int C_STALL_LIMIT = 8,
    parameter int C_IPG         = 2,
    parameter int C_LEN_BITS    = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [C_LEN_BITS-1:0] cfg_len,
    input  logic [15:0]           cfg_count,
    input  logic [7:0]            cfg_seed,
    axis_pkt_gen_if.master        m_axis,
    output logic                  drop_incmpt_pkt,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           sent_cnt,
    output logic [15:0]           drop_cnt
);
    localparam int BPB = bpb(C_DATA_WIDTH);
    localparam int SW  = $clog2(C_STALL_LIMIT + 1);
    localparam int GW  = (C_IPG > 1) ? $clog2(C_IPG) : 1;

    pkt_state_t                  state_q, state_d;
    logic [C_LEN_BITS-1:0]       len_q, len_d;
    logic [15:0]                 count_q, count_d;
    logic [7:0]                  seed_q, seed_d;
    logic [PKT_IDX_BITS-1:0]     pkt_idx_q, pkt_idx_d;
    logic [C_LEN_BITS-1:0]       off_q, off_d;
    logic [SW-1:0]               stall_q, stall_d;
    logic                        started_q, started_d;
    logic [15:0]                 run_q, run_d;
    logic [GW-1:0]               gap_q, gap_d;
    logic                        tvalid_q, tvalid_d;
    logic [C_DATA_WIDTH-1:0]     tdata_q, tdata_d;
    logic                        tlast_q, tlast_d;
    logic [C_MTY_WIDTH-1:0]      mty_q, mty_d;
    logic                        drop_q, drop_d;
    logic                        done_q, done_d;
    logic                        busy_q, busy_d;
    logic [15:0]                 sent_q, sent_d;
    logic [15:0]                 dropc_q, dropc_d;

    logic                        pkt_end;
    logic                        load_beat;
    logic [7:0]                  fmt_base;
    logic [7:0]                  fmt_off;
    logic [C_LEN_BITS-1:0]       fmt_left;
    logic [C_DATA_WIDTH-1:0]     fmt_tdata;
    logic                        fmt_tlast;
    logic [C_MTY_WIDTH-1:0]      fmt_mty;

    axis_beat_fmt #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_MTY_WIDTH  (C_MTY_WIDTH),
        .C_LEN_BITS   (C_LEN_BITS)
    ) u_fmt (
        .pkt_base   (fmt_base),
        .byte_off   (fmt_off),
        .bytes_left (fmt_left),
        .tdata      (fmt_tdata),
        .tlast      (fmt_tlast),
        .mty        (fmt_mty)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        seed_d    = seed_q;
        pkt_idx_d = pkt_idx_q;
        off_d     = off_q;
        stall_d   = stall_q;
        started_d = started_q;
        run_d     = run_q;
        gap_d     = gap_q;
        tvalid_d  = tvalid_q;
        tdata_d   = tdata_q;
        tlast_d   = tlast_q;
        mty_d     = mty_q;
        drop_d    = 1'b0;
        done_d    = 1'b0;
        sent_d    = sent_q;
        dropc_d   = dropc_q;
        pkt_end   = 1'b0;
        load_beat = 1'b0;
        fmt_base  = seed_q + pkt_idx_q;
        fmt_off   = 8'd0;
        fmt_left  = len_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = (cfg_len == '0) ? C_LEN_BITS'(1) : cfg_len;
                    count_d   = cfg_count;
                    seed_d    = cfg_seed;
                    pkt_idx_d = '0;
                    run_d     = '0;
                    off_d     = '0;
                    stall_d   = '0;
                    started_d = 1'b0;
                    fmt_base  = cfg_seed;
                    fmt_left  = len_d;
                    load_beat = 1'b1;
                    state_d   = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tvalid_q && m_axis.tready) begin
                    stall_d = '0;
                    if (tlast_q) begin
                        sent_d    = sent_q + 16'd1;
                        pkt_idx_d = pkt_idx_q + 8'd1;
                        run_d     = run_q + 16'd1;
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        mty_d     = '0;
                        pkt_end   = 1'b1;
                    end else begin
                        // Present the following beat in the acceptance cycle: no bubble.
                        off_d     = off_q + C_LEN_BITS'(BPB);
                        started_d = 1'b1;
                        fmt_off   = off_d[7:0];
                        fmt_left  = len_q - off_d;
                        load_beat = 1'b1;
                    end
                end else if (tvalid_q && started_q) begin
                    stall_d = stall_q + SW'(1);
                    if (stall_d == SW'(C_STALL_LIMIT)) begin
                        state_d   = ST_ABORT;
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        mty_d     = '0;
                        drop_d    = 1'b1;
                        dropc_d   = dropc_q + 16'd1;
                        pkt_idx_d = pkt_idx_q + 8'd1;
                        run_d     = run_q + 16'd1;
                    end
                end
            end
            ST_ABORT: begin
                pkt_end = 1'b1;
            end
            ST_GAP: begin
                if (stop) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (gap_q == '0) begin
                    state_d   = ST_SEND;
                    off_d     = '0;
                    stall_d   = '0;
                    started_d = 1'b0;
                    load_beat = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared completion check after a finished or abandoned packet.
        if (pkt_end) begin
            if (((count_q != 16'd0) && (run_d == count_q)) || stop) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end else if (C_IPG == 0) begin
                state_d   = ST_SEND;
                off_d     = '0;
                stall_d   = '0;
                started_d = 1'b0;
                fmt_base  = seed_q + pkt_idx_d;
                load_beat = 1'b1;
            end else begin
                state_d = ST_GAP;
                gap_d   = GW'(C_IPG - 1);
            end
        end

        if (load_beat) begin
            tvalid_d = 1'b1;
            tdata_d  = fmt_tdata;
            tlast_d  = fmt_tlast;
            mty_d    = fmt_mty;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            count_q   <= '0;
            seed_q    <= '0;
            pkt_idx_q <= '0;
            off_q     <= '0;
            stall_q   <= '0;
            started_q <= 1'b0;
            run_q     <= '0;
            gap_q     <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
            mty_q     <= '0;
            drop_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= '0;
            dropc_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            seed_q    <= seed_d;
            pkt_idx_q <= pkt_idx_d;
            off_q     <= off_d;
            stall_q   <= stall_d;
            started_q <= started_d;
            run_q     <= run_d;
            gap_q     <= gap_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tlast_q   <= tlast_d;
            mty_q     <= mty_d;
            drop_q    <= drop_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
            dropc_q   <= dropc_d;
        end
    end

    assign m_axis.tvalid    = tvalid_q;
    assign m_axis.tdata     = tdata_q;
    assign m_axis.tlast     = tlast_q;
    assign m_axis.tuser_mty = mty_q;
    assign drop_incmpt_pkt  = drop_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign sent_cnt         = sent_q;
    assign drop_cnt         = dropc_q;

endmodule
